// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (MEM), data first with a fetch starvation guard.
// Latency: grant on the first edge after a request, done combinational with mem_ack, so 2 cycles minimum.
// Backpressure: the loser is held via stall_if/stall_mem; mem_* stay stable until mem_ack or timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic       TMO_EN     = (TIMEOUT > 0);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic       discard;

  logic busy;
  logic tmo_hit;
  logic grant_if;
  logic grant_d;

  // Arbitration and timeout decode; a flushed fetch never wins, data wins until fetch has waited STARVE_MAX grants
  always_comb begin
    busy     = (state != IDLE);
    tmo_hit  = TMO_EN & busy & (tmo_cnt == TMO_LAST) & ~mem_ack;
    grant_if = (state == IDLE) & if_req & ~if_flush & (~d_req | (starve_cnt == STARVE_LIM));
    grant_d  = (state == IDLE) & d_req & ~grant_if;
  end

  // Completion, error and stall outputs follow mem_ack in the same cycle; stalls are forced low during reset
  always_comb begin
    if_done   = (state == BUSY_IF) & mem_ack & ~discard;
    d_done    = (state == BUSY_D) & mem_ack;
    if_err    = (state == BUSY_IF) & tmo_hit & ~discard;
    d_err     = (state == BUSY_D) & tmo_hit;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    stall_if  = rst & if_req & ~if_done & ~if_err;
    stall_mem = rst & d_req & ~d_done & ~d_err;
  end

  // Port-owner FSM with registered memory request fields, starvation and timeout counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      discard    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          discard <= 1'b0;
          if (grant_if) begin
            state      <= BUSY_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= 4'hF;
            starve_cnt <= '0;
          end else if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            if (!if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ack || tmo_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            tmo_cnt <= '0;
            discard <= 1'b0;
          end else begin
            if (TMO_EN) begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (state == BUSY_IF && if_flush) begin
              discard <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port of the pipelined femtoRV32 core between the IF stage (fetch) and the MEM stage (load/store).
- Sequences one memory transaction at a time with a req/ack handshake toward memory, and gives data accesses priority with a starvation guard for fetch.
- Generates per-stage stall signals, handles fetch cancellation on branch flush, and provides a bus timeout with error reporting.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending; 1..15
- TIMEOUT, 64, cycles a transaction waits for mem_ack before abort; 0 disables the timeout; max 255

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done or if_err
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard the outstanding or pending fetch (branch taken)
- if_rdata  out  DATA_W  fetched instruction, valid with if_done
- if_done  out  1  fetch complete
- if_err  out  1  fetch timed out
- d_req  in  1  data request, level, held until d_done or d_err
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  4  byte enables
- d_rdata  out  DATA_W  load data, valid with d_done
- d_done  out  1  data access complete
- d_err  out  1  data access timed out
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze pipeline from EX/MEM backward
- mem_req  out  1  memory request, registered
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/4  registered transaction fields
- mem_ack  in  1  memory completes the current transaction this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- FSM states:
  - IDLE: mem_req=0.
  - BUSY_IF: fetch owns the port.
  - BUSY_D: data owns the port.
- Reset (rst=0, asynchronous):
  - State=IDLE, mem_req=0, mem_* fields=0, starve_cnt=0, tmo_cnt=0, discard=0.
  - All done/err outputs are 0; stalls are forced to 0 while rst=0.
  - A transaction in flight is abandoned; memory must tolerate mem_req dropping.
- Arbitration (IDLE, at the rising edge):
  - d_req only: go to BUSY_D.
  - if_req only: go to BUSY_IF, unless if_flush=1, in which case stay IDLE.
  - Both: grant data unless starve_cnt==STARVE_MAX, in which case grant fetch.
  - On every grant, mem_req=1 and the mem_* fields are loaded from the winner's inputs.
  - Earliest ack cycle is the cycle after the request is sampled, so minimum latency is 2 cycles from req to done.
- BUSY state:
  - mem_req and the mem_* fields are held stable until mem_ack.
  - Completion is combinational from mem_ack:
    - if_done = (state==BUSY_IF) & mem_ack & ~discard
    - d_done = (state==BUSY_D) & mem_ack
    - if_rdata and d_rdata pass mem_rdata through.
  - On the mem_ack edge: mem_req=0, return to IDLE.
  - A requester still asserting req after its done edge is issuing a new request. This gives back-to-back throughput of one transaction per 2 cycles with 1-cycle memory.
- Starvation counter:
  - starve_cnt increments on each data grant made while if_req=1, saturating at STARVE_MAX.
  - Cleared on any fetch grant, and on any data grant made while if_req=0.
- Flush:
  - if_flush in BUSY_IF sets discard=1. The transaction still completes on memory, but if_done is suppressed.
  - discard clears on the ack edge.
  - if_flush in IDLE blocks a fetch grant that cycle only.
  - if_flush in BUSY_D has no effect.
- Timeout (TIMEOUT>0):
  - tmo_cnt counts BUSY cycles without ack.
  - When tmo_cnt==TIMEOUT-1 and mem_ack=0: pulse owner's err for 1 cycle (if_err suppressed if discard=1), set mem_req=0, go to IDLE, clear tmo_cnt.
  - mem_ack in the same cycle wins: normal done, no err.
- Stalls:
  - stall_if = if_req & ~if_done & ~if_err
  - stall_mem = d_req & ~d_done & ~d_err
- Simultaneous d_req rise and mem_ack for a fetch: fetch completes; data is granted next IDLE edge.

Test Plan:
- Fetch only, mem_ack 1 cycle after mem_req, mem_rdata=0x00500093 → if_done high 2 cycles after if_req with if_rdata=0x00500093; stall_if high 1 cycle, low on done cycle.
- Both requesting continuously, STARVE_MAX=4, 1-cycle memory → grant order D,D,D,D,IF,D,D,D,D,IF…; no fetch waits more than 5 grants.
- Store d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011 with memory stalling ack 3 cycles → mem_* stable for 4 cycles; d_done on ack cycle; stall_mem high until then.
- if_flush asserted 1 cycle into BUSY_IF, ack 2 cycles later → no if_done; state IDLE after ack; a new fetch to 0x40 is granted next.
- TIMEOUT=8, no ack for data load → d_err pulse exactly on 8th BUSY cycle; mem_req drops next edge; later ack on a fresh transaction gives normal d_done.
- rst asserted mid-BUSY_D → mem_req, d_done, stall_mem go 0 immediately without clk; after release, the first arbitration grants with starve_cnt=0.
